// File: rtl/interboard_pkg.sv
// rtl/interboard_pkg.sv - Shared message-type constants and receiver states for the interboard link
package interboard_pkg;

  localparam logic [2:0] MSG_RESET  = 3'd0;
  localparam logic [2:0] MSG_START  = 3'd1;
  localparam logic [2:0] MSG_NUMBER = 3'd2;
  localparam logic [2:0] MSG_WIN    = 3'd3;

  localparam int HDR_FLAG_BIT = 5;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_HDR_ACK,
    RX_WAIT_BODY,
    RX_BODY_ACK,
    RX_DROP_ACK
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - Two-flop synchroniser for board pins entering the clk domain
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/interboard_receiver.sv
// rtl/interboard_receiver.sv - Four-phase Request/Ack receiver reassembling header+body frames
// Optional watchdog compiled in with INTERBOARD_RX_TIMEOUT_EN.
module interboard_receiver
  import interboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic [2:0] interboard_msg_type,
  output logic [4:0] interboard_number,
  output logic       interboard_rst,
  output logic       rx_err
);

  logic      req_s;
  logic      hdr_w;
  rx_state_e state_q;
  logic [2:0] type_q;
  logic [4:0] num_q;
  logic [2:0] out_type_q;
  logic [4:0] out_num_q;
  logic      ack_q;
  logic      en_q;
  logic      rst_strobe_q;
  logic      err_q;

  sync_2ff #(.WIDTH(1)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (Request_in),
    .q_o (req_s)
  );

  assign hdr_w = inter_data_in[HDR_FLAG_BIT];

`ifdef INTERBOARD_RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             advance;
  logic             timeout;

  // Every waiting state leaves on exactly one req_s level, so this marks a state change.
  assign advance = (state_q == RX_IDLE || state_q == RX_WAIT_BODY) ? req_s : !req_s;
  assign timeout = (state_q != RX_IDLE) && !advance && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RX_IDLE;
      type_q       <= '0;
      num_q        <= '0;
      out_type_q   <= '0;
      out_num_q    <= '0;
      ack_q        <= 1'b0;
      en_q         <= 1'b0;
      rst_strobe_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef INTERBOARD_RX_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      en_q         <= 1'b0;
      rst_strobe_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        RX_IDLE: if (req_s) begin
          ack_q <= 1'b1;
          if (hdr_w) begin
            type_q  <= inter_data_in[2:0];
            state_q <= RX_HDR_ACK;
          end else begin
            err_q   <= 1'b1;
            state_q <= RX_DROP_ACK;
          end
        end
        RX_HDR_ACK: if (!req_s) begin
          ack_q   <= 1'b0;
          state_q <= RX_WAIT_BODY;
        end
        RX_WAIT_BODY: if (req_s) begin
          ack_q <= 1'b1;
          if (hdr_w) begin
            // A second header restarts the frame rather than being dropped.
            err_q   <= 1'b1;
            type_q  <= inter_data_in[2:0];
            state_q <= RX_HDR_ACK;
          end else begin
            num_q   <= inter_data_in[4:0];
            state_q <= RX_BODY_ACK;
          end
        end
        RX_BODY_ACK: if (!req_s) begin
          ack_q        <= 1'b0;
          out_type_q   <= type_q;
          out_num_q    <= num_q;
          en_q         <= 1'b1;
          rst_strobe_q <= (type_q == MSG_RESET);
          state_q      <= RX_IDLE;
        end
        RX_DROP_ACK: if (!req_s) begin
          ack_q   <= 1'b0;
          state_q <= RX_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= RX_IDLE;
        end
      endcase
`ifdef INTERBOARD_RX_TIMEOUT_EN
      if (timeout) begin
        err_q   <= 1'b1;
        ack_q   <= 1'b0;
        state_q <= RX_IDLE;
        cnt_q   <= '0;
      end else if (advance || state_q == RX_IDLE) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
`endif
    end
  end

  assign Ack_out             = ack_q;
  assign interboard_en       = en_q;
  assign interboard_msg_type = out_type_q;
  assign interboard_number   = out_num_q;
  assign interboard_rst      = rst_strobe_q;
  assign rx_err              = err_q;

endmodule

// File: tb/tb_interboard_receiver.sv
// tb/tb_interboard_receiver.sv - Self-checking bench for interboard_receiver against a frame-level model
module tb_interboard_receiver;
  import interboard_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Request_in = 1'b0;
  logic [5:0] inter_data_in = 6'd0;
  logic       Ack_out;
  logic       interboard_en;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;
  logic       interboard_rst;
  logic       rx_err;

  int checks = 0;
  int fails  = 0;

  int en_seen = 0, err_seen = 0, rstb_seen = 0, rst_lone = 0;

  bit         m_pend = 1'b0;
  bit         m_last_deliver = 1'b0;
  logic [2:0] m_ptype = 3'd0;
  logic [2:0] m_type = 3'd0;
  logic [4:0] m_num = 5'd0;
  int         m_en = 0, m_err = 0, m_rst = 0;

  interboard_receiver #(.TIMEOUT_CYCLES(20)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Request_in          (Request_in),
    .inter_data_in       (inter_data_in),
    .Ack_out             (Ack_out),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_number   (interboard_number),
    .interboard_rst      (interboard_rst),
    .rx_err              (rx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (interboard_en === 1'b1) en_seen++;
    if (rx_err === 1'b1) err_seen++;
    if (interboard_rst === 1'b1) rstb_seen++;
    if (interboard_rst === 1'b1 && interboard_en !== 1'b1) rst_lone++;
  end

  // Peer-level view: a header opens a frame, a body closes an open one, anything else is an error.
  task automatic model_beat(input logic [5:0] d);
    m_last_deliver = 1'b0;
    if (d[5]) begin
      if (m_pend) m_err++;
      m_pend  = 1'b1;
      m_ptype = d[2:0];
    end else if (m_pend) begin
      m_pend = 1'b0;
      m_type = m_ptype;
      m_num  = d[4:0];
      m_en++;
      if (m_ptype == 3'd0) m_rst++;
      m_last_deliver = 1'b1;
    end else begin
      m_err++;
    end
  endtask

  task automatic wait_ack(input logic level, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (Ack_out !== level && n < 50);
    if (Ack_out !== level) n = -1;
  endtask

  task automatic phase_up(input logic [5:0] d, input bit raise);
    int n;
    if (raise) begin
      @(negedge clk);
      inter_data_in = d;
      Request_in    = 1'b1;
    end
    wait_ack(1'b1, n);
    checks++;
    if (n !== 3) begin
      fails++;
      $display("FAIL ack_rise_latency: got %0d clk, expected 3", n);
    end
    model_beat(d);
  endtask

  task automatic phase_down(input int hold);
    int n, en_at;
    repeat (hold) @(negedge clk);
    Request_in    = 1'b0;
    inter_data_in = 6'($urandom);
    n = 0;
    en_at = -1;
    while (Ack_out !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
      if (interboard_en === 1'b1 && en_at < 0) en_at = n;
    end
    checks++;
    if (n !== 3) begin
      fails++;
      $display("FAIL ack_fall_latency: got %0d clk, expected 3", n);
    end
    checks++;
    if (en_at !== (m_last_deliver ? n : -1)) begin
      fails++;
      $display("FAIL strobe_at_ack_fall: strobe at %0d, expected %0d", en_at, m_last_deliver ? n : -1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (en_seen !== m_en) begin
      fails++;
      $display("FAIL en_count: got %0d, expected %0d", en_seen, m_en);
    end
    checks++;
    if (err_seen !== m_err) begin
      fails++;
      $display("FAIL err_count: got %0d, expected %0d", err_seen, m_err);
    end
    checks++;
    if (rstb_seen !== m_rst || rst_lone !== 0) begin
      fails++;
      $display("FAIL rst_strobe: got %0d (lone %0d), expected %0d (lone 0)", rstb_seen, rst_lone, m_rst);
    end
    checks++;
    if (interboard_msg_type !== m_type || interboard_number !== m_num) begin
      fails++;
      $display("FAIL held_fields: got type %0d num %0d, expected type %0d num %0d",
               interboard_msg_type, interboard_number, m_type, m_num);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({Ack_out, interboard_en, interboard_rst, rx_err} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_strobes: got %b, expected 0000", {Ack_out, interboard_en, interboard_rst, rx_err});
    end
    checks++;
    if (interboard_msg_type !== 3'd0 || interboard_number !== 5'd0) begin
      fails++;
      $display("FAIL reset_fields: got type %0d num %0d, expected 0 0", interboard_msg_type, interboard_number);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal_frame;
    phase_up(6'b100010, 1'b1);
    phase_down(10);
    repeat (10) @(negedge clk);
    phase_up(6'b001101, 1'b1);
    phase_down(10);
    checks++;
    if (interboard_msg_type !== 3'd2 || interboard_number !== 5'd13) begin
      fails++;
      $display("FAIL normal_frame: got type %0d num %0d, expected 2 13", interboard_msg_type, interboard_number);
    end
  endtask

  task automatic test_reset_msg;
    phase_up(6'b100000, 1'b1);
    phase_down(4);
    phase_up(6'b000000, 1'b1);
    phase_down(4);
    checks++;
    if (rstb_seen !== 1 || interboard_msg_type !== MSG_RESET || interboard_number !== 5'd0) begin
      fails++;
      $display("FAIL reset_msg: got rst strobes %0d type %0d num %0d, expected 1 0 0",
               rstb_seen, interboard_msg_type, interboard_number);
    end
  endtask

  task automatic test_orphan;
    phase_up(6'b000111, 1'b1);
    phase_down(5);
  endtask

  task automatic test_resync;
    phase_up(6'b100001, 1'b1);
    phase_down(3);
    phase_up(6'b100011, 1'b1);
    phase_down(3);
    phase_up(6'b000101, 1'b1);
    phase_down(3);
    checks++;
    if (interboard_msg_type !== 3'd3 || interboard_number !== 5'd5) begin
      fails++;
      $display("FAIL resync: got type %0d num %0d, expected 3 5", interboard_msg_type, interboard_number);
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    phase_up(6'b100110, 1'b1);
    phase_down(3);
    @(negedge clk);
    inter_data_in = 6'b001010;
    Request_in    = 1'b1;
    wait_ack(1'b1, n);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (Ack_out !== 1'b0) begin
      fails++;
      $display("FAIL async_ack_drop: got %b, expected 0", Ack_out);
    end
    m_pend = 1'b0;
    m_type = 3'd0;
    m_num  = 5'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (en_seen !== m_en || interboard_msg_type !== 3'd0 || interboard_number !== 5'd0) begin
      fails++;
      $display("FAIL reset_mid_frame: got strobes %0d type %0d num %0d, expected %0d 0 0",
               en_seen, interboard_msg_type, interboard_number, m_en);
    end
    rst = 1'b1;
    phase_up(6'b001010, 1'b0);
    phase_down(4);
    phase_up(6'b100010, 1'b1);
    phase_down(2);
    phase_up(6'b011110, 1'b1);
    phase_down(2);
  endtask

  task automatic test_timeout;
    int n, err_at;
    phase_up(6'b100001, 1'b1);
    repeat (2) @(negedge clk);
    Request_in = 1'b0;
    n = 0;
    err_at = -1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (rx_err === 1'b1 && err_at < 0) err_at = n;
    end
`ifdef INTERBOARD_RX_TIMEOUT_EN
    m_pend = 1'b0;
    m_err++;
    checks++;
    if (err_at !== 23) begin
      fails++;
      $display("FAIL timeout_err: rx_err at %0d clk after drop, expected 23", err_at);
    end
`else
    checks++;
    if (err_at !== -1) begin
      fails++;
      $display("FAIL no_timeout: rx_err at %0d clk, expected none", err_at);
    end
`endif
    checks++;
    if (Ack_out !== 1'b0 || err_seen !== m_err) begin
      fails++;
      $display("FAIL timeout_state: ack %b errs %0d, expected 0 %0d", Ack_out, err_seen, m_err);
    end
    phase_up(6'b000101, 1'b1);
    phase_down(3);
  endtask

  task automatic test_random;
    logic [5:0] d;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) d = {3'b100, 3'($urandom)};
      else d = {1'b0, 5'($urandom)};
      phase_up(d, 1'b1);
      phase_down(int'($urandom_range(12, 1)));
      repeat ($urandom_range(8, 0)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_reset_msg();
    test_orphan();
    test_resync();
    test_reset_mid_frame();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
